complete_arbiter: RTL

COMPLETE_ARBITER -- requirements
Module: complete_arbiter

---
 rtl/complete_arbiter_if.sv | 42 ++++
 rtl/complete_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/complete_arbiter_if.sv
// Completion bus between the functional units and the completion arbiter.
// It carries the CDB/ROB broadcast channels and the occupancy count.
interface complete_arbiter_if #(
  parameter int NUM_FU    = 3,
  parameter int CDB_WIDTH = 2,
  parameter int BUF_DEPTH = 8,
  parameter int PR_W      = 6,
  parameter int ROB_W     = 5,
  parameter int XLEN      = 32,
  parameter int PC_W      = 32
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [NUM_FU-1:0]                 fu_valid;
  logic [NUM_FU-1:0][PR_W-1:0]       fu_pr_idx;
  logic [NUM_FU-1:0][ROB_W-1:0]      fu_rob_idx;
  logic [NUM_FU-1:0][XLEN-1:0]       fu_dest_value;
  logic [NUM_FU-1:0]                 fu_take_branch;
  logic [NUM_FU-1:0][PC_W-1:0]       fu_target_pc;
  logic [NUM_FU-1:0]                 fu_ready;

  logic [CDB_WIDTH-1:0]              cdb_valid;
  logic [CDB_WIDTH-1:0][PR_W-1:0]    cdb_t_idx;
  logic [CDB_WIDTH-1:0]              rob_complete;
  logic [CDB_WIDTH-1:0][ROB_W-1:0]   rob_idx;
  logic [CDB_WIDTH-1:0][XLEN-1:0]    rob_dest_value;
  logic [CDB_WIDTH-1:0]              rob_precise_state_enable;
  logic [CDB_WIDTH-1:0][PC_W-1:0]    rob_target_pc;
  logic [CNT_W-1:0]                  buf_count;

  modport master (
    output fu_valid, fu_pr_idx, fu_rob_idx, fu_dest_value, fu_take_branch, fu_target_pc,
    input  fu_ready, cdb_valid, cdb_t_idx, rob_complete, rob_idx, rob_dest_value,
           rob_precise_state_enable, rob_target_pc, buf_count
  );

  modport slave (
    input  fu_valid, fu_pr_idx, fu_rob_idx, fu_dest_value, fu_take_branch, fu_target_pc,
    output fu_ready, cdb_valid, cdb_t_idx, rob_complete, rob_idx, rob_dest_value,
           rob_precise_state_enable, rob_target_pc, buf_count
  );
endinterface

// File: rtl/complete_arbiter.sv
// Completion arbiter: buffers FU completions in a circular FIFO and broadcasts
// up to CDB_WIDTH of them per cycle on registered CDB/ROB channels, oldest first.
module complete_arbiter #(
  parameter int NUM_FU    = 3,
  parameter int CDB_WIDTH = 2,
  parameter int BUF_DEPTH = 8,
  parameter int PR_W      = 6,
  parameter int ROB_W     = 5,
  parameter int XLEN      = 32,
  parameter int PC_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  complete_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PR_W-1:0]  pr_idx;
    logic [ROB_W-1:0] rob_idx;
    logic [XLEN-1:0]  value;
    logic             take_branch;
    logic [PC_W-1:0]  target_pc;
  } entry_t;

  entry_t                      mem_q [BUF_DEPTH];
  entry_t                      mem_d [BUF_DEPTH];
  logic   [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
  logic   [CNT_W-1:0]          count_q, count_d;
  logic   [CNT_W-1:0]          free_cnt, pop_cnt, push_cnt;
  logic   [NUM_FU-1:0]         ready;
  logic   [CDB_WIDTH-1:0]      valid_q, valid_d;
  entry_t [CDB_WIDTH-1:0]      out_q, out_d;

  // Port i may accept only if i earlier ports could also fit, so any subset fits.
  always_comb begin
    ready    = '0;
    free_cnt = CNT_W'(BUF_DEPTH) - count_q;
    for (int i = 0; i < NUM_FU; i++) begin
      ready[i] = (CNT_W'(i) < free_cnt) && !squash;
    end
    pop_cnt = (count_q < CNT_W'(CDB_WIDTH)) ? count_q : CNT_W'(CDB_WIDTH);
  end

  always_comb begin
    mem_d    = mem_q;
    push_cnt = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (bus.fu_valid[i] && ready[i]) begin
        mem_d[tail_q + push_cnt[PTR_W-1:0]] = '{
          pr_idx:      bus.fu_pr_idx[i],
          rob_idx:     bus.fu_rob_idx[i],
          value:       bus.fu_dest_value[i],
          take_branch: bus.fu_take_branch[i],
          target_pc:   bus.fu_target_pc[i]
        };
        push_cnt = push_cnt + CNT_W'(1);
      end
    end

    valid_d = '0;
    out_d   = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (CNT_W'(k) < pop_cnt) begin
        valid_d[k] = 1'b1;
        out_d[k]   = mem_q[head_q + PTR_W'(k)];
      end
    end

    head_d  = head_q + pop_cnt[PTR_W-1:0];
    tail_d  = tail_q + push_cnt[PTR_W-1:0];
    count_d = count_q - pop_cnt + push_cnt;

    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      out_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus.fu_ready  = ready;
  assign bus.buf_count = count_q;

  always_comb begin
    bus.cdb_valid                = valid_q;
    bus.rob_complete             = valid_q;
    bus.cdb_t_idx                = '0;
    bus.rob_idx                  = '0;
    bus.rob_dest_value           = '0;
    bus.rob_precise_state_enable = '0;
    bus.rob_target_pc            = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      bus.cdb_t_idx[k]                = out_q[k].take_branch ? '0 : out_q[k].pr_idx;
      bus.rob_idx[k]                  = out_q[k].rob_idx;
      bus.rob_dest_value[k]           = out_q[k].value;
      bus.rob_precise_state_enable[k] = out_q[k].take_branch;
      bus.rob_target_pc[k]            = out_q[k].target_pc;
    end
  end
endmodule
